// File: rtl/mem_responder.sv
// Purpose: single-port unified I/D memory responder with byte-lane loads/stores and error signalling.
// Latency: 1+WAIT_STATES cycles from handshake to a one-cycle rsp_valid pulse.
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored, not queued.
// Optional build macro: MEM_RESPONDER_MISALIGN_TRAP_EN (misaligned H/HU/W accesses fault).
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter preload; the WAIT_STATES=0 case never loads it.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // funct3 size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [3:0]  next_cnt;

  // Request fields captured at acceptance
  logic        lat_write;
  logic [2:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Fields of the request being serviced. With zero wait states the access
  // happens on the acceptance edge itself, so the live request is used in IDLE.
  logic        cur_write;
  logic [2:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic          handshake;
  logic          enter_resp;
  logic          range_err;
  logic          size_err;
  logic          mis_err;
  logic          access_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_rep;

  logic [31:0] mem [DEPTH_WORDS];

  assign handshake = req_valid && req_ready;
  assign rsp_valid = (state == S_RESP);

  assign cur_write = (state == S_IDLE) ? req_write : lat_write;
  assign cur_size  = (state == S_IDLE) ? req_size  : lat_size;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;

  // The access (load sample / store commit) happens only on the edge entering RESP.
  assign enter_resp = rst && (next_state == S_RESP) && (state != S_RESP);

  // Next-state, wait counter and ready generation
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    req_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = rst;
        if (req_valid && rst) begin
          if (WAIT_STATES > 0) begin
            next_state = S_WAIT;
            next_cnt   = CNT_INIT;
          end else begin
            next_state = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          next_state = S_RESP;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Capture the request on handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_write <= 1'b0;
      lat_size  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (handshake) begin
      lat_write <= req_write;
      lat_size  <= req_size;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Error classification: out of range, illegal size, optional misalignment
  always_comb begin
    range_err = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    size_err  = 1'b1;
    case (cur_size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_err = 1'b0;
      default:                        size_err = 1'b1;
    endcase
    mis_err = 1'b0;
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    if (((cur_size == SZ_H) || (cur_size == SZ_HU)) && cur_addr[0]) begin
      mis_err = 1'b1;
    end
    if ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00)) begin
      mis_err = 1'b1;
    end
`endif
    access_err = range_err || size_err || mis_err;
  end

  assign word_idx = cur_addr[AW+1:2];
  assign rd_word  = mem[word_idx];
  assign byte_sel = rd_word[8*cur_addr[1:0] +: 8];
  assign half_sel = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Load lane selection and sign/zero extension
  always_comb begin
    ld_data = 32'd0;
    case (cur_size)
      SZ_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ld_data = {24'd0, byte_sel};
      SZ_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ld_data = {16'd0, half_sel};
      SZ_W:    ld_data = rd_word;
      default: ld_data = 32'd0;
    endcase
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    byte_en = 4'b0000;
    wr_rep  = cur_wdata;
    case (cur_size)
      SZ_B: begin
        byte_en = 4'b0001 << cur_addr[1:0];
        wr_rep  = {4{cur_wdata[7:0]}};
      end
      SZ_H: begin
        byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{cur_wdata[15:0]}};
      end
      SZ_W: begin
        byte_en = 4'b1111;
        wr_rep  = cur_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_rep  = cur_wdata;
      end
    endcase
  end

  // Memory array write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (enter_resp && cur_write && !access_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wr_rep[8*b +: 8];
        end
      end
    end
  end

  // Registered response payload, sampled on the edge entering RESP
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_err   <= access_err;
      rsp_rdata <= (access_err || cur_write) ? 32'd0 : ld_data;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: one instance with 1 wait state,
// one with 3 wait states for handshake-pattern and mid-operation reset sequences.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WS1   = 1;
  localparam int WS3   = 3;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        valid1, valid3;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready1, ready3;
  logic        rv1, rv3;
  logic [31:0] rd1, rd3;
  logic        er1, er3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(ready3),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic w, logic [2:0] s, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] er, logic ee);
    vec_t v;
    v.name = n; v.wr = w; v.size = s; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request to the selected instance and wait (bounded) for its response.
  task automatic do_req(input int which, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    rd = 32'd0; er = 1'b0; lat = 0; guard = 0;
    while (!((which == 1) ? ready1 : ready3) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    if (which == 1) valid1 = 1'b1; else valid3 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0; valid3 = 1'b0;
    lat = 1;
    while (!((which == 1) ? rv1 : rv3) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if ((which == 1) ? rv1 : rv3) begin
      rd = (which == 1) ? rd1 : rd3;
      er = (which == 1) ? er1 : er3;
    end else begin
      checks++; errors++;
      $display("FAIL response_timeout: got no rsp_valid expected one within 40 cycles");
      lat = -1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          seen;
    logic        exp_pat [6];

    rst1 = 1'b0; rst3 = 1'b0; valid1 = 1'b0; valid3 = 1'b0;
    req_write = 1'b0; req_size = 3'b010; req_addr = 32'd0; req_wdata = 32'd0;

    // Vector table, applied in order against the 1-wait-state instance
    vecs.push_back(mk("sw_10",        1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk("lw_10_a",      1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("sb_11",        1'b1, 3'b000, 32'h11,   32'h0000007F, 32'h0,        1'b0));
    vecs.push_back(mk("lw_10_b",      1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD7FEF, 1'b0));
    vecs.push_back(mk("lb_13",        1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0));
    vecs.push_back(mk("lbu_13",       1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0));
    vecs.push_back(mk("lb_10",        1'b0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0));
    vecs.push_back(mk("lbu_11",       1'b0, 3'b100, 32'h11,   32'h0,        32'h0000007F, 1'b0));
    vecs.push_back(mk("lh_12",        1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0));
    vecs.push_back(mk("lhu_12",       1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0));
    vecs.push_back(mk("sh_12",        1'b1, 3'b001, 32'h12,   32'hFFFF1234, 32'h0,        1'b0));
    vecs.push_back(mk("lw_10_c",      1'b0, 3'b010, 32'h10,   32'h0,        32'h12347FEF, 1'b0));
    vecs.push_back(mk("lw_oor",       1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("sw_oor",       1'b1, 3'b010, 32'h1000, 32'h55555555, 32'h0,        1'b1));
    vecs.push_back(mk("st_size011",   1'b1, 3'b011, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1));
    vecs.push_back(mk("lw_10_d",      1'b0, 3'b010, 32'h10,   32'h0,        32'h12347FEF, 1'b0));
    vecs.push_back(mk("ld_size111",   1'b0, 3'b111, 32'h10,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("sw_14",        1'b1, 3'b010, 32'h14,   32'h0,        32'h0,        1'b0));
    vecs.push_back(mk("sb_16",        1'b1, 3'b000, 32'h16,   32'h123456AB, 32'h0,        1'b0));
    vecs.push_back(mk("lw_14",        1'b0, 3'b010, 32'h14,   32'h0,        32'h00AB0000, 1'b0));
    vecs.push_back(mk("lb_16",        1'b0, 3'b000, 32'h16,   32'h0,        32'hFFFFFFAB, 1'b0));
    vecs.push_back(mk("st_size110",   1'b1, 3'b110, 32'h14,   32'hFFFFFFFF, 32'h0,        1'b1));
    vecs.push_back(mk("lw_14_b",      1'b0, 3'b010, 32'h14,   32'h0,        32'h00AB0000, 1'b0));
    vecs.push_back(mk("sw_last",      1'b1, 3'b010, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0));
    vecs.push_back(mk("lw_last",      1'b0, 3'b010, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0));
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_12_mis",    1'b0, 3'b010, 32'h12,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("lh_11_mis",    1'b0, 3'b001, 32'h11,   32'h0,        32'h0,        1'b1));
    vecs.push_back(mk("sw_12_mis",    1'b1, 3'b010, 32'h12,   32'h11111111, 32'h0,        1'b1));
    vecs.push_back(mk("lw_10_e",      1'b0, 3'b010, 32'h10,   32'h0,        32'h12347FEF, 1'b0));
`else
    vecs.push_back(mk("lw_12_align",  1'b0, 3'b010, 32'h12,   32'h0,        32'h12347FEF, 1'b0));
    vecs.push_back(mk("lh_11_align",  1'b0, 3'b001, 32'h11,   32'h0,        32'h00007FEF, 1'b0));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rv1}, 32'd0);
    chk("rst_rsp_rdata", rd1, 32'd0);
    chk("rst_rsp_err",   {31'd0, er1}, 32'd0);
    chk("rst_ready1_low", {31'd0, ready1}, 32'd0);
    chk("rst_ready3_low", {31'd0, ready3}, 32'd0);
    rst1 = 1'b1; rst3 = 1'b1;
    #1;
    chk("rel_ready1_high", {31'd0, ready1}, 32'd1);
    chk("rel_ready3_high", {31'd0, ready3}, 32'd1);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_req(1, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(1 + WS1));
    end

    // Three wait states: seed a word, then check the ready pattern with valid held
    do_req(3, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, rd, er, lat);
    chk("ws3_sw_latency", 32'(lat), 32'(1 + WS3));
    exp_pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    req_write = 1'b0; req_size = 3'b010; req_addr = 32'h20;
    valid3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("ws3_ready_c%0d", c), {31'd0, ready3}, {31'd0, exp_pat[c]});
      if (c == 4) begin
        chk("ws3_rsp_valid_c4", {31'd0, rv3}, 32'd1);
        chk("ws3_rdata_c4", rd3, 32'hA5A5A5A5);
      end
      if (c == 5) valid3 = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // Reset during the second WAIT cycle of a store aborts it
    req_write = 1'b1; req_size = 3'b010; req_addr = 32'h20; req_wdata = 32'h5A5A5A5A;
    valid3 = 1'b1;
    @(posedge clk); #1;
    valid3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_low", {31'd0, ready3}, 32'd0);
    seen = 0;
    if (rv3) seen++;
    rst3 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (rv3) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    chk("midrst_rdata_clear", rd3, 32'd0);
    do_req(3, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("midrst_mem_kept", rd, 32'hA5A5A5A5);
    chk("midrst_reload_err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
